// File: rtl/quad_position_counter.sv
// Turns decoder cw/ccw pulses into a bounded position with detent divider, acceleration and clamp/wrap.
// Latency: 1 cycle from a qualifying pulse or load to pos/changed. No backpressure; a pulse is taken every cycle en is high.
module quad_position_counter #(
    parameter int WIDTH           = 8,
    parameter int MIN_VAL         = 0,
    parameter int MAX_VAL         = 255,
    parameter int PULSES_PER_STEP = 1,
    parameter int FAST_WINDOW     = 0,
    parameter int FAST_STEP       = 4,
    parameter int WRAP            = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cw_in,
    input  logic             ccw_in,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pos,
    output logic             changed,
    output logic             dir,
    output logic             at_min,
    output logic             at_max
);

    localparam int GW = (FAST_WINDOW > 1) ? $clog2(FAST_WINDOW + 1) : 1;
    localparam int PW = WIDTH + 2;

    typedef logic signed [PW-1:0] wide_t;

    localparam wide_t          MIN_W   = wide_t'(MIN_VAL);
    localparam wide_t          MAX_W   = wide_t'(MAX_VAL);
    localparam wide_t          RANGE_W = wide_t'(MAX_VAL - MIN_VAL + 1);
    localparam wide_t          FAST_W  = wide_t'(FAST_STEP);
    localparam wide_t          ONE_W   = wide_t'(1);
    localparam logic [GW-1:0]  GAP_SAT = GW'(FAST_WINDOW);
    localparam logic signed [4:0] ACC_LIM = 5'(PULSES_PER_STEP);

    logic [WIDTH-1:0]  pos_q, pos_d;
    logic signed [4:0] acc_q, acc_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              dir_q, dir_d;
    logic              changed_q, changed_d;

    logic              pulse;
    logic signed [4:0] acc_nxt;
    logic              step_up, step_dn, fast;
    wide_t             pos_ext, lv_ext, mag, t_up, t_dn;

    always_comb begin
        pos_d     = pos_q;
        acc_d     = acc_q;
        dir_d     = dir_q;
        gap_d     = (gap_q == GAP_SAT) ? gap_q : gap_q + GW'(1);

        pulse     = en && !load && (cw_in ^ ccw_in);
        acc_nxt   = acc_q + (cw_in ? 5'sd1 : -5'sd1);
        step_up   = pulse && (acc_nxt == ACC_LIM);
        step_dn   = pulse && (acc_nxt == -ACC_LIM);

        // Acceleration only continues a run in the same direction; a reversal always moves by one.
        fast      = (FAST_WINDOW > 0) && (gap_q < GAP_SAT) && (step_up == dir_q);
        mag       = fast ? FAST_W : ONE_W;

        pos_ext   = $signed({2'b00, pos_q});
        lv_ext    = $signed({2'b00, load_val});
        t_up      = pos_ext + mag;
        t_dn      = pos_ext - mag;

        if (load) begin
            if (lv_ext < MIN_W) begin
                pos_d = WIDTH'(MIN_VAL);
            end else if (lv_ext > MAX_W) begin
                pos_d = WIDTH'(MAX_VAL);
            end else begin
                pos_d = load_val;
            end
            acc_d = '0;
            gap_d = GAP_SAT;
        end else if (pulse) begin
            acc_d = acc_nxt;
            if (step_up || step_dn) begin
                acc_d = '0;
                gap_d = '0;
                dir_d = step_up;
                if (step_up) begin
                    if (t_up > MAX_W) begin
                        pos_d = (WRAP != 0) ? WIDTH'(t_up - RANGE_W) : WIDTH'(MAX_VAL);
                    end else begin
                        pos_d = WIDTH'(t_up);
                    end
                end else begin
                    if (t_dn < MIN_W) begin
                        pos_d = (WRAP != 0) ? WIDTH'(t_dn + RANGE_W) : WIDTH'(MIN_VAL);
                    end else begin
                        pos_d = WIDTH'(t_dn);
                    end
                end
            end
        end

        changed_d = (pos_d != pos_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= WIDTH'(MIN_VAL);
            acc_q     <= '0;
            gap_q     <= GAP_SAT;
            dir_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            acc_q     <= acc_d;
            gap_q     <= gap_d;
            dir_q     <= dir_d;
            changed_q <= changed_d;
        end
    end

    assign pos     = pos_q;
    assign changed = changed_q;
    assign dir     = dir_q;
    assign at_min  = (pos_q == WIDTH'(MIN_VAL));
    assign at_max  = (pos_q == WIDTH'(MAX_VAL));

endmodule

// File: tb/tb_quad_position_counter.sv
// Drives four differently configured counters from shared stimulus and checks them against a cycle-indexed model.
// Directed steps cover the main behaviours, then random traffic exercises the rest.
module tb_quad_position_counter;

    localparam int C_W   [4] = '{9, 8, 8, 8};
    localparam int C_MIN [4] = '{0, 0, 0, 3};
    localparam int C_MAX [4] = '{255, 10, 10, 200};
    localparam int C_PPS [4] = '{1, 1, 1, 4};
    localparam int C_FW  [4] = '{0, 0, 8, 8};
    localparam int C_FS  [4] = '{4, 4, 4, 4};
    localparam int C_WRAP[4] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       rst, cw, ccw, en, load;
    logic [8:0] lv;

    logic [8:0] pos0;
    logic [7:0] pos1, pos2, pos3;
    logic [3:0] chg_w, dir_w, amin_w, amax_w;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    int m_pos [4];
    int m_acc [4];
    int m_dir [4];
    int m_chg [4];
    int m_last[4];

    always #5 clk = ~clk;

    quad_position_counter #(.WIDTH(C_W[0]), .MIN_VAL(C_MIN[0]), .MAX_VAL(C_MAX[0]), .PULSES_PER_STEP(C_PPS[0]),
        .FAST_WINDOW(C_FW[0]), .FAST_STEP(C_FS[0]), .WRAP(C_WRAP[0])) u0 (
        .clk(clk), .rst(rst), .cw_in(cw), .ccw_in(ccw), .en(en), .load(load), .load_val(lv),
        .pos(pos0), .changed(chg_w[0]), .dir(dir_w[0]), .at_min(amin_w[0]), .at_max(amax_w[0]));

    quad_position_counter #(.WIDTH(C_W[1]), .MIN_VAL(C_MIN[1]), .MAX_VAL(C_MAX[1]), .PULSES_PER_STEP(C_PPS[1]),
        .FAST_WINDOW(C_FW[1]), .FAST_STEP(C_FS[1]), .WRAP(C_WRAP[1])) u1 (
        .clk(clk), .rst(rst), .cw_in(cw), .ccw_in(ccw), .en(en), .load(load), .load_val(lv[7:0]),
        .pos(pos1), .changed(chg_w[1]), .dir(dir_w[1]), .at_min(amin_w[1]), .at_max(amax_w[1]));

    quad_position_counter #(.WIDTH(C_W[2]), .MIN_VAL(C_MIN[2]), .MAX_VAL(C_MAX[2]), .PULSES_PER_STEP(C_PPS[2]),
        .FAST_WINDOW(C_FW[2]), .FAST_STEP(C_FS[2]), .WRAP(C_WRAP[2])) u2 (
        .clk(clk), .rst(rst), .cw_in(cw), .ccw_in(ccw), .en(en), .load(load), .load_val(lv[7:0]),
        .pos(pos2), .changed(chg_w[2]), .dir(dir_w[2]), .at_min(amin_w[2]), .at_max(amax_w[2]));

    quad_position_counter #(.WIDTH(C_W[3]), .MIN_VAL(C_MIN[3]), .MAX_VAL(C_MAX[3]), .PULSES_PER_STEP(C_PPS[3]),
        .FAST_WINDOW(C_FW[3]), .FAST_STEP(C_FS[3]), .WRAP(C_WRAP[3])) u3 (
        .clk(clk), .rst(rst), .cw_in(cw), .ccw_in(ccw), .en(en), .load(load), .load_val(lv[7:0]),
        .pos(pos3), .changed(chg_w[3]), .dir(dir_w[3]), .at_min(amin_w[3]), .at_max(amax_w[3]));

    function automatic int dut_pos(input int i);
        case (i)
            0:       return int'(pos0);
            1:       return int'(pos1);
            2:       return int'(pos2);
            default: return int'(pos3);
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Gap is measured from cycle numbers: cycles elapsed since the last step, minus the step cycle itself.
    task automatic model_step(input int i, input bit r, input bit c, input bit cc, input bit e,
                              input bit l, input int v);
        int t, mag, vv, rng;
        bit up;
        rng = C_MAX[i] - C_MIN[i] + 1;
        if (r) begin
            m_pos[i] = C_MIN[i]; m_acc[i] = 0; m_dir[i] = 0; m_chg[i] = 0; m_last[i] = -1000000;
        end else if (l) begin
            vv = v & ((1 << C_W[i]) - 1);
            if (vv < C_MIN[i]) vv = C_MIN[i];
            if (vv > C_MAX[i]) vv = C_MAX[i];
            m_chg[i]  = (vv != m_pos[i]) ? 1 : 0;
            m_pos[i]  = vv;
            m_acc[i]  = 0;
            m_last[i] = -1000000;
        end else begin
            m_chg[i] = 0;
            if (e && (c != cc)) begin
                m_acc[i] += c ? 1 : -1;
                if (m_acc[i] == C_PPS[i] || m_acc[i] == -C_PPS[i]) begin
                    up = (m_acc[i] > 0);
                    m_acc[i] = 0;
                    mag = (C_FW[i] > 0 && (cyc - m_last[i] - 1) < C_FW[i] && int'(up) == m_dir[i])
                          ? C_FS[i] : 1;
                    t = up ? m_pos[i] + mag : m_pos[i] - mag;
                    if (t > C_MAX[i]) t = (C_WRAP[i] != 0) ? t - rng : C_MAX[i];
                    if (t < C_MIN[i]) t = (C_WRAP[i] != 0) ? t + rng : C_MIN[i];
                    m_chg[i]  = (t != m_pos[i]) ? 1 : 0;
                    m_pos[i]  = t;
                    m_dir[i]  = up ? 1 : 0;
                    m_last[i] = cyc;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit c, input bit cc, input bit e, input bit l, input int v);
        rst = r; cw = c; ccw = cc; en = e; load = l; lv = 9'(v);
        @(posedge clk);
        for (int i = 0; i < 4; i++) model_step(i, r, c, cc, e, l, v);
        cyc++;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.pos", i),     dut_pos(i),      m_pos[i]);
            chk($sformatf("u%0d.changed", i), int'(chg_w[i]),  m_chg[i]);
            chk($sformatf("u%0d.dir", i),     int'(dir_w[i]),  m_dir[i]);
            chk($sformatf("u%0d.at_min", i),  int'(amin_w[i]), (m_pos[i] == C_MIN[i]) ? 1 : 0);
            chk($sformatf("u%0d.at_max", i),  int'(amax_w[i]), (m_pos[i] == C_MAX[i]) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nchg;

        // Reset
        tick(1, 0, 0, 1, 0, 0);
        tick(1, 1, 0, 1, 1, 77);
        chk("rst_pos_u0", dut_pos(0), 0);
        chk("rst_pos_u3", dut_pos(3), 3);
        chk("rst_dir_u0", int'(dir_w[0]), 0);
        chk("rst_chg_u0", int'(chg_w[0]), 0);
        chk("rst_atmin_u3", int'(amin_w[3]), 1);

        // Three spaced cw pulses
        for (int k = 0; k < 3; k++) begin
            tick(0, 1, 0, 1, 0, 0);
            chk("cw_pos_u0", dut_pos(0), k + 1);
            chk("cw_chg_u0", int'(chg_w[0]), 1);
            idle(1);
            chk("cw_chg_off_u0", int'(chg_w[0]), 0);
            idle(8);
        end
        chk("cw_dir_u0", int'(dir_w[0]), 1);

        // Reset mid-accumulation loses the partial detent
        tick(1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        tick(1, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) tick(0, 1, 0, 1, 0, 0);
        chk("rstmid_hold_u3", dut_pos(3), 3);
        tick(0, 1, 0, 1, 0, 0);
        chk("rstmid_step_u3", dut_pos(3), 4);
        chk("rstmid_chg_u3", int'(chg_w[3]), 1);

        // Detent divider with a reversal
        tick(1, 0, 0, 1, 0, 0);
        nchg = 0;
        for (int k = 0; k < 6; k++) begin
            tick(0, (k != 2), (k == 2), 1, 0, 0);
            if (chg_w[3]) nchg++;
            idle(1);
        end
        chk("detent_pos_u3", dut_pos(3), 4);
        chk("detent_nchg_u3", nchg, 1);

        // Clamp vs wrap at MAX
        tick(0, 0, 0, 1, 1, 10);
        chk("load10_u1", dut_pos(1), 10);
        tick(0, 1, 0, 1, 0, 0);
        chk("clamp_pos_u1", dut_pos(1), 10);
        chk("clamp_chg_u1", int'(chg_w[1]), 0);
        chk("clamp_atmax_u1", int'(amax_w[1]), 1);
        chk("wrap_pos_u2", dut_pos(2), 0);
        chk("wrap_chg_u2", int'(chg_w[2]), 1);

        // Acceleration
        tick(1, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 1, 0, 0);
        chk("fast_first_u2", dut_pos(2), 1);
        idle(4);
        tick(0, 1, 0, 1, 0, 0);
        chk("fast_step_u2", dut_pos(2), 5);
        idle(14);
        tick(0, 1, 0, 1, 0, 0);
        chk("fast_expired_u2", dut_pos(2), 6);
        idle(3);
        tick(0, 0, 1, 1, 0, 0);
        chk("fast_reversal_u2", dut_pos(2), 5);
        chk("fast_rev_dir_u2", int'(dir_w[2]), 0);

        // Load clamps and discards a same-cycle pulse; cw+ccw together is ignored
        tick(0, 1, 0, 1, 1, 300);
        chk("load300_u0", dut_pos(0), 255);
        chk("load300_chg_u0", int'(chg_w[0]), 1);
        chk("load44_clamp_u1", dut_pos(1), 10);
        tick(0, 1, 1, 1, 0, 0);
        chk("both_pos_u0", dut_pos(0), 255);
        chk("both_chg_u0", int'(chg_w[0]), 0);

        // en = 0 holds position; load still honoured
        for (int k = 0; k < 5; k++) begin
            tick(0, 1, 0, 0, 0, 0);
            chk("en0_pos_u0", dut_pos(0), 255);
            chk("en0_chg_u0", int'(chg_w[0]), 0);
        end
        tick(0, 0, 0, 0, 1, 7);
        chk("en0_load_u0", dut_pos(0), 7);

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            tick(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 90),
                 ($urandom_range(0, 99) < 3),
                 int'($urandom_range(0, 511)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/quad_position_counter.md
Name: quad_position_counter

Overview:
- Downstream consumer of the quadrature state decoder: takes its single-cycle cw/ccw pulses and maintains a bounded position value.
- Supports a detent divider, optional speed acceleration, clamp or wrap at the limits, and synchronous preset load.
- Output feeds UI/menu logic and parameter registers that need a stable position plus a one-cycle "changed" strobe.

Parameters:
- WIDTH, 8, position width in bits.
- MIN_VAL, 0, lowest legal position (unsigned, fits WIDTH).
- MAX_VAL, 255, highest legal position (MAX_VAL > MIN_VAL).
- PULSES_PER_STEP, 1, decoder pulses required per position step (1..15).
- FAST_WINDOW, 0, cycles; a step arriving in fewer cycles than this after a same-direction step uses FAST_STEP. 0 disables acceleration.
- FAST_STEP, 4, step magnitude when accelerated (1..MAX_VAL-MIN_VAL).
- WRAP, 0, 0 = clamp at limits, 1 = wrap around the range.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- cw_in  input  1  single-cycle clockwise pulse from the decoder.
- ccw_in  input  1  single-cycle counter-clockwise pulse from the decoder.
- en  input  1  1 = accept pulses; 0 = ignore pulses. Load is still honoured when en = 0.
- load  input  1  synchronous preset strobe.
- load_val  input  WIDTH  preset value.
- pos  output  WIDTH  registered position.
- changed  output  1  registered one-cycle strobe; high in the cycle pos first shows a new value.
- dir  output  1  registered direction of the last applied step: 1 = cw, 0 = ccw.
- at_min  output  1  combinational, pos == MIN_VAL.
- at_max  output  1  combinational, pos == MAX_VAL.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - pos = MIN_VAL, changed = 0, dir = 0.
  - Sub-accumulator = 0.
  - Gap timer saturated at FAST_WINDOW, so the first step after reset is never fast.
  - Reset overrides load and pulses in the same cycle.
- Pulse qualification:
  - A pulse counts only when en = 1, load = 0, and exactly one of cw_in/ccw_in is high.
  - cw_in and ccw_in both high in the same cycle: ignored, no state change.
- Sub-accumulator (signed, range ±PULSES_PER_STEP):
  - cw pulse: +1. ccw pulse: −1.
  - On reaching +PULSES_PER_STEP: issue an up-step and clear to 0.
  - On reaching −PULSES_PER_STEP: issue a down-step and clear to 0.
  - Reversal before a step simply counts back toward 0; no step is issued.
- Gap timer:
  - Increments every cycle, saturating at FAST_WINDOW.
  - Clears to 0 in the cycle a step is issued.
- Step magnitude:
  - FAST_STEP if FAST_WINDOW > 0, gap timer < FAST_WINDOW, and the step direction equals dir.
  - Otherwise 1.
- Position update, computed at WIDTH+2 bits to avoid overflow; latency is 1 cycle (pulse at edge N → new pos and changed visible after edge N):
  - Up-step: t = pos + mag. If t > MAX_VAL:
    - WRAP = 0: pos = MAX_VAL.
    - WRAP = 1: pos = t − (MAX_VAL − MIN_VAL + 1).
  - Down-step: t = pos − mag. If t < MIN_VAL:
    - WRAP = 0: pos = MIN_VAL.
    - WRAP = 1: pos = t + (MAX_VAL − MIN_VAL + 1).
  - dir is updated to the step direction on every issued step, even when clamped.
- changed:
  - 1 for exactly one cycle when the new pos differs from the old pos.
  - A clamped step at a limit gives changed = 0 and no pos change.
- Load:
  - Highest priority after reset.
  - pos = load_val clamped into [MIN_VAL, MAX_VAL]; sub-accumulator cleared; dir unchanged; gap timer saturated.
  - changed = 1 only if the clamped value differs from the old pos.
  - Pulses arriving in the load cycle are discarded.
- en = 0:
  - Sub-accumulator and pos hold; gap timer keeps counting.
  - changed = 0 unless a load occurs.
- Reset mid-accumulation:
  - A partially accumulated detent is lost.
  - The first step after reset needs a full PULSES_PER_STEP pulses.

Test Plan:
- Reset, then 3 cw pulses spaced 10 cycles apart (defaults) → pos 0→1→2→3; changed high 1 cycle after each pulse; dir = 1.
- PULSES_PER_STEP = 4: cw, cw, ccw, cw, cw, cw → exactly one up-step, on the last pulse; pos = 1; changed pulses once.
- WRAP = 0, MAX_VAL = 10, load_val = 10, then cw → pos stays 10, changed = 0, at_max = 1. Repeat with WRAP = 1 → pos = 0, changed = 1.
- FAST_WINDOW = 8, FAST_STEP = 4: cw at cycle 0, then cw at cycle 5 → pos 0→1→5. Next cw at cycle 20 → pos 6. A ccw within 8 cycles of that → pos 5 (no fast step on reversal).
- load = 1 with load_val = 300 (WIDTH = 9, MAX_VAL = 255) and cw_in = 1 in the same cycle → pos = 255; the pulse is discarded. cw_in and ccw_in high together → no change.
- en = 0 during 5 cw pulses → pos holds, changed = 0. rst asserted after 2 of 4 pulses (PULSES_PER_STEP = 4) → pos = MIN_VAL, and a full 4 further pulses are needed for the next step.
